// File: rtl/pp_hazard_unit_if.sv
// Hazard-unit bus: ID-stage instruction description and redirect in,
// forwarding selects, stall and flush vector out.
interface pp_hazard_unit_if #(
   parameter int REG_AW       = 5,
   parameter int DEPTH        = 3,
   parameter int REDIRECT_STG = 1
);
   localparam int FWD_W   = $clog2(DEPTH + 1);
   localparam int FLUSH_W = REDIRECT_STG + 2;

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_rw;
   logic              id_regwr;
   logic              id_load;
   logic              redirect;
   logic [FWD_W-1:0]  fwd_a;
   logic [FWD_W-1:0]  fwd_b;
   logic              stall;
   logic [FLUSH_W-1:0] flush;

   // Pipeline side: describes the ID instruction and consumes the controls.
   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_rw, id_regwr, id_load, redirect,
      input  fwd_a, fwd_b, stall, flush
   );

   // Hazard unit side.
   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_rw, id_regwr, id_load, redirect,
      output fwd_a, fwd_b, stall, flush
   );
endinterface

// File: rtl/pp_hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipe: scoreboard of in-flight
// writers (EX..WR), operand forwarding selects, load-use interlock,
// redirect flush and saturating performance counters.
module pp_hazard_unit #(
   parameter int REG_AW       = 5,
   parameter int DEPTH        = 3,
   parameter int LOAD_STAGE   = 1,
   parameter int REDIRECT_STG = 1,
   parameter int FWD_W        = $clog2(DEPTH + 1),
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   pp_hazard_unit_if.slave  hz,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] retire_cnt
);
   localparam int FLUSH_W = REDIRECT_STG + 2;

   // Scoreboard, index 0 = EX ... DEPTH-1 = WR
   logic              v_reg  [DEPTH];
   logic [REG_AW-1:0] rw_reg [DEPTH];
   logic              wr_reg [DEPTH];
   logic              ld_reg [DEPTH];

   logic [FWD_W-1:0]  sel_a;
   logic [FWD_W-1:0]  sel_b;
   logic              late_a;
   logic              late_b;
   logic              stall_int;

   // Forwarding select: scan oldest to youngest so the youngest matching writer
   // overwrites and wins. late_x marks a load whose data is not yet forwardable.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      late_a = 1'b0;
      late_b = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (v_reg[k] && wr_reg[k] && rw_reg[k] == hz.id_rs &&
             hz.id_rs != '0 && hz.id_use_rs) begin
            sel_a  = FWD_W'(k + 1);
            late_a = ld_reg[k] && (k < LOAD_STAGE);
         end
         if (v_reg[k] && wr_reg[k] && rw_reg[k] == hz.id_rt &&
             hz.id_rt != '0 && hz.id_use_rt) begin
            sel_b  = FWD_W'(k + 1);
            late_b = ld_reg[k] && (k < LOAD_STAGE);
         end
      end
   end

   // Redirect overrides the interlock: the stalled instruction is being killed anyway.
   assign stall_int = hz.id_valid && !hz.redirect && (late_a || late_b);
   assign hz.stall  = stall_int;
   assign hz.fwd_a  = sel_a;
   assign hz.fwd_b  = sel_b;
   assign hz.flush  = {FLUSH_W{hz.redirect}};

   // Scoreboard shift: entry 0 takes the ID instruction or a bubble; entries
   // younger than the redirecting stage are killed on a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            v_reg[k]  <= 1'b0;
            rw_reg[k] <= '0;
            wr_reg[k] <= 1'b0;
            ld_reg[k] <= 1'b0;
         end
      end else begin
         if (stall_int || hz.redirect) begin
            v_reg[0]  <= 1'b0;
            rw_reg[0] <= '0;
            wr_reg[0] <= 1'b0;
            ld_reg[0] <= 1'b0;
         end else begin
            v_reg[0]  <= hz.id_valid;
            rw_reg[0] <= hz.id_rw;
            wr_reg[0] <= hz.id_regwr;
            ld_reg[0] <= hz.id_load;
         end
         for (int k = 1; k < DEPTH; k++) begin
            v_reg[k]  <= v_reg[k-1] && !(hz.redirect && (k < REDIRECT_STG));
            rw_reg[k] <= rw_reg[k-1];
            wr_reg[k] <= wr_reg[k-1];
            ld_reg[k] <= ld_reg[k-1];
         end
      end
   end

   // Saturating event counters, updated on the edge closing the qualifying cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (stall_int && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (hz.redirect && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
         if (v_reg[DEPTH-1] && retire_cnt != '1)
            retire_cnt <= retire_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pp_hazard_unit.sv
// Directed bench for pp_hazard_unit: forwarding, load-use stall, $0 handling,
// youngest-writer priority, redirect flush, async reset and retire counting.
`timescale 1ns/1ps
module tb_pp_hazard_unit;
   localparam int REG_AW       = 5;
   localparam int DEPTH        = 3;
   localparam int LOAD_STAGE   = 1;
   localparam int REDIRECT_STG = 1;
   localparam int FWD_W        = $clog2(DEPTH + 1);
   localparam int CNT_W        = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] retire_cnt;

   int total = 0;
   int bad   = 0;

   pp_hazard_unit_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .REDIRECT_STG(REDIRECT_STG)) hz_if ();

   pp_hazard_unit #(
      .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE),
      .REDIRECT_STG(REDIRECT_STG), .FWD_W(FWD_W), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hz         (hz_if),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0d", tag, got);
      end
   endtask

   // Drive the ID-stage instruction description.
   task automatic issue(input logic valid, input int rs, input int rt,
                        input logic use_rs, input logic use_rt,
                        input int rw, input logic regwr, input logic load);
      hz_if.id_valid  = valid;
      hz_if.id_rs     = REG_AW'(rs);
      hz_if.id_rt     = REG_AW'(rt);
      hz_if.id_use_rs = use_rs;
      hz_if.id_use_rt = use_rt;
      hz_if.id_rw     = REG_AW'(rw);
      hz_if.id_regwr  = regwr;
      hz_if.id_load   = load;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      issue(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      hz_if.redirect = 1'b0;

      // Reset state
      #2;
      check_val("rst fwd_a", int'(hz_if.fwd_a), 0);
      check_val("rst fwd_b", int'(hz_if.fwd_b), 0);
      check_val("rst stall", int'(hz_if.stall), 0);
      check_val("rst flush", int'(hz_if.flush), 0);
      check_val("rst stall_cnt", int'(stall_cnt), 0);
      check_val("rst flush_cnt", int'(flush_cnt), 0);
      check_val("rst retire_cnt", int'(retire_cnt), 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // 1: add $1,$2,$3 ; sub $4,$1,$5
      issue(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, 1'b0);
      @(negedge clk);
      check_val("t1 add fwd_a", int'(hz_if.fwd_a), 0);
      cyc();
      issue(1'b1, 1, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0);
      @(negedge clk);
      check_val("t1 sub fwd_a", int'(hz_if.fwd_a), 1);
      check_val("t1 sub fwd_b", int'(hz_if.fwd_b), 0);
      check_val("t1 sub stall", int'(hz_if.stall), 0);
      cyc();

      // 2: lw $2,0($0) ; add $3,$2,$2
      issue(1'b1, 0, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1);
      @(negedge clk);
      check_val("t2 lw stall", int'(hz_if.stall), 0);
      cyc();
      issue(1'b1, 2, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
      @(negedge clk);
      check_val("t2 use stall", int'(hz_if.stall), 1);
      cyc();
      @(negedge clk);
      check_val("t2 held stall", int'(hz_if.stall), 0);
      check_val("t2 held fwd_a", int'(hz_if.fwd_a), 2);
      check_val("t2 held fwd_b", int'(hz_if.fwd_b), 2);
      check_val("t2 stall_cnt", int'(stall_cnt), 1);
      cyc();

      // 3: addi $0,$0,5 ; add $6,$0,$0
      issue(1'b1, 0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      cyc();
      issue(1'b1, 0, 0, 1'b1, 1'b1, 6, 1'b1, 1'b0);
      @(negedge clk);
      check_val("t3 fwd_a", int'(hz_if.fwd_a), 0);
      check_val("t3 fwd_b", int'(hz_if.fwd_b), 0);
      check_val("t3 stall", int'(hz_if.stall), 0);
      cyc();

      // 4: $7 written by EX and MEM entries, read by ID
      issue(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0);
      cyc();
      issue(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0);
      cyc();
      issue(1'b1, 7, 7, 1'b1, 1'b0, 8, 1'b0, 1'b0);
      @(negedge clk);
      check_val("t4 fwd_a youngest", int'(hz_if.fwd_a), 1);
      check_val("t4 fwd_b unused", int'(hz_if.fwd_b), 0);
      cyc();

      // 5: redirect with load-use pending
      issue(1'b1, 0, 0, 1'b0, 1'b0, 9, 1'b1, 1'b1);
      cyc();
      issue(1'b1, 9, 0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
      hz_if.redirect = 1'b1;
      @(negedge clk);
      check_val("t5 stall", int'(hz_if.stall), 0);
      check_val("t5 flush", int'(hz_if.flush), 7);
      cyc();
      hz_if.redirect = 1'b0;
      issue(1'b1, 10, 9, 1'b1, 1'b1, 12, 1'b0, 1'b0);
      @(negedge clk);
      check_val("t5 flush off", int'(hz_if.flush), 0);
      check_val("t5 killed fwd_a", int'(hz_if.fwd_a), 0);
      check_val("t5 older fwd_b", int'(hz_if.fwd_b), 2);
      check_val("t5 flush_cnt", int'(flush_cnt), 1);
      check_val("t5 stall_cnt", int'(stall_cnt), 1);
      cyc();

      // 6: async reset in the middle of a stall, then a 10-instruction stream
      issue(1'b1, 0, 0, 1'b0, 1'b0, 11, 1'b1, 1'b1);
      cyc();
      issue(1'b1, 11, 0, 1'b1, 1'b0, 13, 1'b1, 1'b0);
      @(negedge clk);
      check_val("t6 pre stall", int'(hz_if.stall), 1);
      #1;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      check_val("t6 stall", int'(hz_if.stall), 0);
      check_val("t6 fwd_a", int'(hz_if.fwd_a), 0);
      check_val("t6 stall_cnt", int'(stall_cnt), 0);
      check_val("t6 flush_cnt", int'(flush_cnt), 0);
      check_val("t6 retire_cnt", int'(retire_cnt), 0);
      for (int i = 0; i < 10; i++) begin
         issue(1'b1, 0, 0, 1'b0, 1'b0, i + 1, 1'b1, 1'b0);
         cyc();
      end
      issue(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      cyc();
      cyc();
      check_val("t6 retire +2", int'(retire_cnt), 9);
      cyc();
      check_val("t6 retire +3", int'(retire_cnt), 10);
      check_val("t6 stall_cnt end", int'(stall_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
